// File: rtl/dds_pkg.sv
// dds_pkg: shared ADC/DAC sample width and the capture FSM state encoding.
`default_nettype none

package dds_pkg;

  localparam int ADC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/adc_clk_gen.sv
// adc_clk_gen: divides clk down to the ADC conversion clock and marks the
// cycle on which adc_clk falls, where the bus is sampled.
`default_nettype none

module adc_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic adc_clk_o,
  output logic strobe_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  // Counter parks at zero while stopped so the first running cycle is t0.
  always_comb begin
    div_cnt_d = '0;
    if (run_i && (div_cnt_q != C_LAST)) begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign adc_clk_o = run_i && (div_cnt_q < C_HALF);
  assign strobe_o  = run_i && (div_cnt_q == C_HALF);

endmodule

`default_nettype wire

// File: rtl/adc_capture.sv
// adc_capture: runs an external pipelined ADC, flushes its latency, averages
// blocks of samples and hands each result to the AM or DDS consumer.
`default_nettype none

module adc_capture
  import dds_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int ADC_LAT  = 3,
  parameter int DEC_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             mode_i,
  output logic             adc_clk_o,
  input  logic [ADC_W-1:0] adc_data_i,
  output logic [ADC_W-1:0] am_data_o,
  output logic             am_valid_o,
  input  logic             am_ready_i,
  output logic [ADC_W-1:0] dds_data_o,
  output logic             dds_valid_o,
  input  logic             dds_ready_i,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int FW = (ADC_LAT > 0) ? $clog2(ADC_LAT + 1) : 1;
  localparam int SW = DEC_LOG2 + 1;
  localparam int AW = ADC_W + DEC_LOG2;
  localparam logic [FW-1:0] C_FLUSH_DONE = FW'(ADC_LAT);
  localparam logic [SW-1:0] C_SAMP_LAST  = SW'((1 << DEC_LOG2) - 1);

  state_e            state_q, state_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic [SW-1:0]     samp_q, samp_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     sum_w;
  logic [ADC_W-1:0]  res_w;
  logic              res_wr_w;
  logic              run_w;
  logic              strobe_w;

  logic [ADC_W-1:0]  am_data_q, am_data_d, dds_data_q, dds_data_d;
  logic              am_valid_q, am_valid_d, dds_valid_q, dds_valid_d;
  logic              overrun_q, overrun_d;
  logic              wr_am_w, wr_dds_w;

  assign run_w = (state_q != ST_IDLE);

  adc_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .run_i     (run_w),
    .adc_clk_o (adc_clk_o),
    .strobe_o  (strobe_w)
  );

  assign sum_w = acc_q + AW'(adc_data_i);
  assign res_w = sum_w[AW-1:DEC_LOG2];

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    samp_d   = samp_q;
    acc_d    = acc_q;
    res_wr_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (flush_q == C_FLUSH_DONE) begin
          state_d = ST_RUN;
        end else if (strobe_w) begin
          flush_d = flush_q + FW'(1);
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (strobe_w) begin
          // The last sample of a block goes straight into the result so the
          // next block starts accumulating on the very next strobe.
          if (samp_q == C_SAMP_LAST) begin
            res_wr_w = 1'b1;
            acc_d    = '0;
            samp_d   = '0;
          end else begin
            acc_d  = sum_w;
            samp_d = samp_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      flush_d = '0;
      samp_d  = '0;
      acc_d   = '0;
    end
  end

  assign wr_am_w  = res_wr_w && !mode_i;
  assign wr_dds_w = res_wr_w &&  mode_i;

  always_comb begin
    am_data_d   = am_data_q;
    am_valid_d  = am_valid_q;
    dds_data_d  = dds_data_q;
    dds_valid_d = dds_valid_q;
    overrun_d   = overrun_q;
    if (wr_am_w && (!am_valid_q || am_ready_i)) begin
      am_data_d  = res_w;
      am_valid_d = 1'b1;
    end else if (am_valid_q && am_ready_i) begin
      am_valid_d = 1'b0;
    end
    if (wr_dds_w && (!dds_valid_q || dds_ready_i)) begin
      dds_data_d  = res_w;
      dds_valid_d = 1'b1;
    end else if (dds_valid_q && dds_ready_i) begin
      dds_valid_d = 1'b0;
    end
    if ((wr_am_w && am_valid_q && !am_ready_i) ||
        (wr_dds_w && dds_valid_q && !dds_ready_i)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_q     <= '0;
      samp_q      <= '0;
      acc_q       <= '0;
      am_data_q   <= '0;
      am_valid_q  <= 1'b0;
      dds_data_q  <= '0;
      dds_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      samp_q      <= samp_d;
      acc_q       <= acc_d;
      am_data_q   <= am_data_d;
      am_valid_q  <= am_valid_d;
      dds_data_q  <= dds_data_d;
      dds_valid_q <= dds_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign am_data_o   = am_data_q;
  assign am_valid_o  = am_valid_q;
  assign dds_data_o  = dds_data_q;
  assign dds_valid_o = dds_valid_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = run_w;

endmodule

`default_nettype wire
